seg_scan_display: RTL

Parametrised multiplexed seven-segment driver for the 8-digit board display. It holds a per-digit buffer, time-multiplexes the AN/SEG lines at a programmable scan rate, and has an auto-sequence mode. In auto-sequence mode an internal counter steps the shown values at a slow or fast rate. Step-rate selection uses clock-enable ticks on the single system clock; no derived or muxed clocks.

---
 rtl/seg_scan_display.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/seg_scan_display.sv
// Multiplexed 8-digit seven-segment driver with a per-digit buffer and an
// auto-sequence mode that steps the shown values on clock-enable ticks.
module seg_scan_display #(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned SCAN_DIV  = 50_000,
  parameter int unsigned STEP_SLOW = 50_000_000,
  parameter int unsigned STEP_FAST = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic       mode,
  input  logic       fast,
  output logic       step_tick,
  output logic [7:0] SEG,
  output logic [7:0] AN
);

  localparam int unsigned STEP_MAX = (STEP_SLOW > STEP_FAST) ? STEP_SLOW : STEP_FAST;
  localparam int unsigned SCAN_W   = $clog2(SCAN_DIV);
  localparam int unsigned STEP_W   = $clog2(STEP_MAX);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);
  localparam logic [STEP_W-1:0] SLOW_LAST = STEP_W'(STEP_SLOW - 1);
  localparam logic [STEP_W-1:0] FAST_LAST = STEP_W'(STEP_FAST - 1);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [2:0]        POS_LAST  = 3'(DIGITS - 1);

  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]        pos_q, pos_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [3:0]        offset_q, offset_d;
  logic              fast_q, fast_d;
  logic              step_tick_q, step_tick_d;
  logic [7:0]        seg_q, seg_d;
  logic [7:0]        an_q, an_d;
  logic [4:0]        digit_buf_q [8];
  logic [4:0]        digit_buf_d [8];

  logic              scan_wrap;
  logic [STEP_W-1:0] step_last;
  logic [4:0]        cur_entry;
  logic [3:0]        shown_code;
  logic              shown_blank;

  function automatic logic [7:0] hex_pattern(input logic [3:0] code);
    hex_pattern = 8'hFF;
    case (code)
      4'h0: hex_pattern = 8'hC0;
      4'h1: hex_pattern = 8'hF9;
      4'h2: hex_pattern = 8'hA4;
      4'h3: hex_pattern = 8'hB0;
      4'h4: hex_pattern = 8'h99;
      4'h5: hex_pattern = 8'h92;
      4'h6: hex_pattern = 8'h82;
      4'h7: hex_pattern = 8'hF8;
      4'h8: hex_pattern = 8'h80;
      4'h9: hex_pattern = 8'h98;
      4'hA: hex_pattern = 8'h88;
      4'hB: hex_pattern = 8'h83;
      4'hC: hex_pattern = 8'hC6;
      4'hD: hex_pattern = 8'hA1;
      4'hE: hex_pattern = 8'h86;
      4'hF: hex_pattern = 8'h8E;
      default: hex_pattern = 8'hFF;
    endcase
  endfunction

  // Scan position and digit buffer
  always_comb begin
    scan_wrap  = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SCAN_ONE;
    pos_d      = pos_q;
    if (scan_wrap) begin
      pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 3'd1;
    end

    digit_buf_d = digit_buf_q;
    if (wr_en && (32'(wr_addr) < DIGITS)) begin
      digit_buf_d[wr_addr] = wr_data;
    end
  end

  // A change of fast restarts the interval so the new rate is measured from the toggle
  always_comb begin
    step_last   = fast ? FAST_LAST : SLOW_LAST;
    fast_d      = fast;
    step_tick_d = 1'b0;
    offset_d    = offset_q;
    step_cnt_d  = step_cnt_q + STEP_ONE;
    if (fast != fast_q) begin
      step_cnt_d = '0;
    end else if (step_cnt_q >= step_last) begin
      step_cnt_d  = '0;
      step_tick_d = 1'b1;
      if (mode) begin
        offset_d = offset_q + 4'd1;
      end
    end
  end

  // Output register lags pos by one clk; the wrap cycle blanks to hide ghosting
  always_comb begin
    cur_entry   = digit_buf_q[pos_q];
    shown_code  = mode ? ({pos_q, 1'b0} + offset_q) : cur_entry[3:0];
    shown_blank = ~mode & cur_entry[4];
    an_d        = 8'hFF;
    seg_d       = 8'hFF;
    if (!scan_wrap) begin
      an_d  = ~(8'h01 << pos_q);
      seg_d = shown_blank ? 8'hFF : hex_pattern(shown_code);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      pos_q       <= '0;
      step_cnt_q  <= '0;
      offset_q    <= '0;
      fast_q      <= 1'b0;
      step_tick_q <= 1'b0;
      seg_q       <= '1;
      an_q        <= '1;
      digit_buf_q <= '{default: 5'h10};
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      pos_q       <= pos_d;
      step_cnt_q  <= step_cnt_d;
      offset_q    <= offset_d;
      fast_q      <= fast_d;
      step_tick_q <= step_tick_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      digit_buf_q <= digit_buf_d;
    end
  end

  assign step_tick = step_tick_q;
  assign SEG       = seg_q;
  assign AN        = an_q;

endmodule
